rx_input_buffer: RTL and testbench

RX_INPUT_BUFFER -- requirements
Module: rx_input_buffer

---
 rtl/noc_pkg.sv | 19 +
 rtl/rx_flit_checker.sv | 55 +++++
 rtl/rx_input_buffer.sv | 100 ++++++++++
 tb/tb_rx_input_buffer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: default buffer geometry, flit-type encodings
// carried in the top three bits of every flit, and the packet-sequence
// FSM state type used by the input-buffer flit checker.
package noc_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam int unsigned DEPTH_DEF      = 4;

    localparam int unsigned FLIT_TYPE_W = 3;
    localparam logic [FLIT_TYPE_W-1:0] FLIT_HEADER = 3'b001;
    localparam logic [FLIT_TYPE_W-1:0] FLIT_BODY   = 3'b010;
    localparam logic [FLIT_TYPE_W-1:0] FLIT_TAIL   = 3'b100;

    typedef enum logic {
        SEQ_IDLE   = 1'b0,
        SEQ_IN_PKT = 1'b1
    } seq_state_e;

endpackage

// File: rtl/rx_flit_checker.sv
// Packet-sequence checker for flits accepted by the input buffer.
// Tracks header -> body* -> tail framing; any out-of-order or unknown
// flit type raises a sticky error that only reset clears. The state is
// left untouched on an error flit so later framing is judged from the
// last legal position.
//   clk_i       : clock, rising edge
//   rst_ni      : asynchronous active-low reset
//   wr_en_i     : a flit is being written this cycle
//   flit_type_i : type bits of the flit being written
//   err_seq_o   : sticky sequence error
module rx_flit_checker
    import noc_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   wr_en_i,
    input  logic [FLIT_TYPE_W-1:0] flit_type_i,
    output logic                   err_seq_o
);

    seq_state_e state_q, state_d;
    logic       err_q, err_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= SEQ_IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        if (wr_en_i) begin
            unique case (state_q)
                SEQ_IDLE: begin
                    if (flit_type_i == FLIT_HEADER) state_d = SEQ_IN_PKT;
                    else                            err_d   = 1'b1;
                end
                SEQ_IN_PKT: begin
                    if (flit_type_i == FLIT_BODY)      state_d = SEQ_IN_PKT;
                    else if (flit_type_i == FLIT_TAIL) state_d = SEQ_IDLE;
                    else                               err_d   = 1'b1;
                end
                default: state_d = SEQ_IDLE;
            endcase
        end
    end

    assign err_seq_o = err_q;

endmodule

// File: rtl/rx_input_buffer.sv
// Router input-port FIFO with DRTS/CTS flow control.
// CTS toggles low after every grant, so at most one flit is accepted
// every two cycles. Any of the five output-side read enables pops the
// head flit (several at once still pop only one). Flit framing is
// checked by rx_flit_checker.
//   clk                 : clock, rising edge
//   rst                 : asynchronous active-low reset
//   DRTS                : request-to-send from upstream
//   CTS                 : registered clear-to-send to upstream
//   RX                  : incoming flit
//   read_en_N/E/W/S/L   : pop requests
//   Data_out            : head flit (don't-care when empty)
//   empty, full         : occupancy flags
//   err_seq             : sticky flit-sequence error
module rx_input_buffer
    import noc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned DEPTH      = DEPTH_DEF     // power of two
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  DRTS,
    output logic                  CTS,
    input  logic [DATA_WIDTH-1:0] RX,
    input  logic                  read_en_N,
    input  logic                  read_en_E,
    input  logic                  read_en_W,
    input  logic                  read_en_S,
    input  logic                  read_en_L,
    output logic [DATA_WIDTH-1:0] Data_out,
    output logic                  empty,
    output logic                  full,
    output logic                  err_seq
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  cts_q, cts_d;
    logic                  wr_en, rd_en;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CNT_W'(DEPTH));

    // A grant is only issued while not full, and no other write can land
    // before it is used, so a write never meets a full buffer.
    assign wr_en = DRTS & cts_q;
    assign rd_en = (read_en_N | read_en_E | read_en_W | read_en_S | read_en_L) & ~empty;
    assign cts_d = DRTS & ~cts_q & ~full;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        // Power-of-two depth: pointer wrap is the natural overflow.
        if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        unique case ({wr_en, rd_en})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cts_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            cts_q    <= cts_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= RX;
    end

    assign CTS      = cts_q;
    assign Data_out = mem[rd_ptr_q];

    rx_flit_checker u_checker (
        .clk_i       (clk),
        .rst_ni      (rst),
        .wr_en_i     (wr_en),
        .flit_type_i (RX[DATA_WIDTH-1 -: FLIT_TYPE_W]),
        .err_seq_o   (err_seq)
    );

endmodule

// File: tb/tb_rx_input_buffer.sv
module tb_rx_input_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        DRTS;
    logic        CTS;
    logic [31:0] RX;
    logic        read_en_N, read_en_E, read_en_W, read_en_S, read_en_L;
    logic [31:0] Data_out;
    logic        empty, full, err_seq;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rx_input_buffer #(.DATA_WIDTH(32), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .DRTS      (DRTS),
        .CTS       (CTS),
        .RX        (RX),
        .read_en_N (read_en_N),
        .read_en_E (read_en_E),
        .read_en_W (read_en_W),
        .read_en_S (read_en_S),
        .read_en_L (read_en_L),
        .Data_out  (Data_out),
        .empty     (empty),
        .full      (full),
        .err_seq   (err_seq)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reads();
        read_en_N = 0; read_en_E = 0; read_en_W = 0; read_en_S = 0; read_en_L = 0;
    endtask

    task automatic do_reset();
        rst = 0; DRTS = 0; RX = '0; clear_reads();
        tick();
        rst = 1;
    endtask

    // Hold DRTS until a grant is used; bounded wait.
    task automatic write_flit(input logic [31:0] d);
        int unsigned n;
        n = 0;
        RX = d; DRTS = 1;
        while (!CTS && n < 8) begin tick(); n++; end
        if (!CTS) begin
            checks++; errors++;
            $display("FAIL write_timeout: CTS=%b required 1 for flit %h", CTS, d);
        end else begin
            tick();
        end
        DRTS = 0;
    endtask

    task automatic pop_one();
        read_en_W = 1;
        tick();
        clear_reads();
    endtask

    task automatic test_reset();
        rst = 0; DRTS = 0; RX = '0; clear_reads();
        #2;
        checks++; if (CTS !== 1'b0)     begin errors++; $display("FAIL reset_cts: got %b want 0", CTS); end
        checks++; if (empty !== 1'b1)   begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
        checks++; if (full !== 1'b0)    begin errors++; $display("FAIL reset_full: got %b want 0", full); end
        checks++; if (err_seq !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_seq); end
        tick();
    endtask

    task automatic test_handshake();
        logic exp_cts [4];
        exp_cts[0] = 0; exp_cts[1] = 1; exp_cts[2] = 0; exp_cts[3] = 1;
        rst = 1; DRTS = 1; RX = 32'h2000_0005;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (CTS !== exp_cts[i]) begin errors++; $display("FAIL hs_cts[%0d]: got %b want %b", i, CTS, exp_cts[i]); end
            if (i == 1) begin
                checks++; if (empty !== 1'b1) begin errors++; $display("FAIL hs_empty_c1: got %b want 1", empty); end
            end
            if (i == 2) begin
                checks++; if (empty !== 1'b0) begin errors++; $display("FAIL hs_empty_c3: got %b want 0", empty); end
                checks++; if (Data_out !== 32'h2000_0005) begin errors++; $display("FAIL hs_data: got %h want 20000005", Data_out); end
                RX = 32'h8000_0006;
            end
            if (i < 3) tick();
        end
        // Drop DRTS while CTS=1: the write is cancelled.
        DRTS = 0;
        tick();
        checks++; if (CTS !== 1'b0) begin errors++; $display("FAIL drop_cts: got %b want 0", CTS); end
        checks++; if (Data_out !== 32'h2000_0005) begin errors++; $display("FAIL drop_head: got %h want 20000005", Data_out); end
        pop_one();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drop_nowrite: empty=%b want 1", empty); end
    endtask

    task automatic test_full();
        logic [31:0] f [5];
        f[0] = 32'h2000_0001; f[1] = 32'h4000_0002; f[2] = 32'h4000_0003;
        f[3] = 32'h4000_0004; f[4] = 32'h4000_00AA;
        do_reset();
        for (int i = 0; i < 4; i++) write_flit(f[i]);
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_set: got %b want 1", full); end
        DRTS = 1; RX = f[4];
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (CTS !== 1'b0) begin errors++; $display("FAIL full_cts[%0d]: got %b want 0", i, CTS); end
        end
        checks++; if (Data_out !== f[0]) begin errors++; $display("FAIL full_head: got %h want %h", Data_out, f[0]); end
        read_en_E = 1;
        tick();
        clear_reads();
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL full_pop: full=%b want 0", full); end
        checks++; if (Data_out !== f[1]) begin errors++; $display("FAIL full_pop_head: got %h want %h", Data_out, f[1]); end
        tick();
        checks++; if (CTS !== 1'b1) begin errors++; $display("FAIL full_cts_reen: got %b want 1", CTS); end
        tick();
        DRTS = 0;
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_refill: got %b want 1", full); end
        for (int i = 1; i < 5; i++) begin
            checks++; if (Data_out !== f[i]) begin errors++; $display("FAIL full_drain[%0d]: got %h want %h", i, Data_out, f[i]); end
            pop_one();
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL full_drained: empty=%b want 1", empty); end
        checks++; if (err_seq !== 1'b0) begin errors++; $display("FAIL full_err: got %b want 0", err_seq); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        write_flit(32'h2000_0011);
        write_flit(32'h4000_0012);
        DRTS = 1; RX = 32'h4000_0013;
        tick();
        checks++; if (CTS !== 1'b1) begin errors++; $display("FAIL b2b_cts: got %b want 1", CTS); end
        read_en_L = 1;
        tick();
        DRTS = 0; clear_reads();
        checks++; if (Data_out !== 32'h4000_0012) begin errors++; $display("FAIL b2b_head: got %h want 40000012", Data_out); end
        checks++; if (empty !== 1'b0 || full !== 1'b0) begin errors++; $display("FAIL b2b_flags: empty=%b full=%b want 0 0", empty, full); end
        pop_one();
        checks++; if (Data_out !== 32'h4000_0013) begin errors++; $display("FAIL b2b_second: got %h want 40000013", Data_out); end
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL b2b_cnt2: empty=%b want 0", empty); end
        pop_one();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL b2b_cnt0: empty=%b want 1", empty); end
    endtask

    task automatic test_multi_read();
        do_reset();
        write_flit(32'h2000_0021);
        write_flit(32'h4000_0022);
        write_flit(32'h4000_0023);
        read_en_N = 1; read_en_S = 1;
        tick();
        clear_reads();
        checks++; if (Data_out !== 32'h4000_0022) begin errors++; $display("FAIL multi_head: got %h want 40000022", Data_out); end
        pop_one();
        checks++; if (Data_out !== 32'h4000_0023 || empty !== 1'b0) begin errors++; $display("FAIL multi_cnt: data=%h empty=%b want 40000023 0", Data_out, empty); end
        pop_one();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL multi_empty: got %b want 1", empty); end
        read_en_N = 1;
        tick();
        clear_reads();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL empty_pop: empty=%b want 1", empty); end
        write_flit(32'h4000_0024);
        checks++; if (Data_out !== 32'h4000_0024 || empty !== 1'b0) begin errors++; $display("FAIL empty_pop_ptr: data=%h empty=%b want 40000024 0", Data_out, empty); end
    endtask

    task automatic test_sequence();
        logic [31:0] seq [6];
        logic        exp_err [6];
        seq[0] = 32'h2000_0031; exp_err[0] = 0;
        seq[1] = 32'h4000_0032; exp_err[1] = 0;
        seq[2] = 32'h4000_0033; exp_err[2] = 0;
        seq[3] = 32'h8000_0034; exp_err[3] = 0;
        seq[4] = 32'h4000_0035; exp_err[4] = 1;
        seq[5] = 32'h2000_0036; exp_err[5] = 1;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            write_flit(seq[i]);
            checks++; if (err_seq !== exp_err[i]) begin errors++; $display("FAIL seq_err[%0d]: got %b want %b", i, err_seq, exp_err[i]); end
            if (i == 4) begin
                checks++; if (Data_out !== seq[4]) begin errors++; $display("FAIL seq_stored: got %h want %h", Data_out, seq[4]); end
            end
            pop_one();
        end
        do_reset();
        checks++; if (err_seq !== 1'b0) begin errors++; $display("FAIL seq_reset_clear: got %b want 0", err_seq); end
        write_flit(32'h6000_0037);
        checks++; if (err_seq !== 1'b1) begin errors++; $display("FAIL seq_badtype: got %b want 1", err_seq); end
        checks++; if (Data_out !== 32'h6000_0037) begin errors++; $display("FAIL seq_badtype_stored: got %h want 60000037", Data_out); end
    endtask

    task automatic test_async_reset();
        do_reset();
        write_flit(32'h2000_0041);
        write_flit(32'h4000_0042);
        write_flit(32'h4000_0043);
        DRTS = 1; RX = 32'h4000_0044;
        tick();
        checks++; if (CTS !== 1'b1 || empty !== 1'b0) begin errors++; $display("FAIL ares_pre: CTS=%b empty=%b want 1 0", CTS, empty); end
        #3;
        rst = 0;
        #1;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ares_empty: got %b want 1", empty); end
        checks++; if (CTS !== 1'b0) begin errors++; $display("FAIL ares_cts: got %b want 0", CTS); end
        @(posedge clk);
        #3;
        rst = 1; DRTS = 0;
        tick();
        checks++; if (empty !== 1'b1 || CTS !== 1'b0) begin errors++; $display("FAIL ares_post: empty=%b CTS=%b want 1 0", empty, CTS); end
        write_flit(32'h2000_0045);
        checks++; if (Data_out !== 32'h2000_0045 || empty !== 1'b0) begin errors++; $display("FAIL ares_resume: data=%h empty=%b want 20000045 0", Data_out, empty); end
    endtask

    initial begin
        test_reset();
        test_handshake();
        test_full();
        test_back_to_back();
        test_multi_read();
        test_sequence();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
